pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised two-entry pipeline stage register that supersedes the fixed per-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the five-stage MIPS core. It carries a control field and a data field with a valid/ready handshake, and it breaks the ready path combinationally with a skid entry. It also supports a synchronous flush that turns every held entry into an all-zero bubble (NOP). One instance sits between each pair of adjacent pipeline stages.

## Interface
- CW, 8: control field width (WE, syscall, RW, …); zeroed on flush/bubble
- DW, 64: data field width (ALU result, memory word, …); zeroed on flush/bubble
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept; registered, depends only on state
- in_ctrl  in  CW  upstream control field
- in_data  in  DW  upstream data field
- clear  in  1  synchronous flush (branch taken / exception)
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts; replaces the old `go`
- out_ctrl  out  CW  presented control field; 0 when out_valid=0
- out_data  out  DW  presented data field; 0 when out_valid=0
- occupancy  out  2  entries held: 0, 1 or 2
- stall_cnt  out  16  downstream-stall cycle counter (see Configuration)
- flush_cnt  out  16  flush counter (see Configuration)

## Operation
- Storage: main entry (drives out_*) and skid entry. State: EMPTY (0 held), FULL (main valid), SKID (main and skid valid).
- in_ready = (state != SKID). out_valid = (state != EMPTY). Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
- EMPTY: transfer in -> main <= in, FULL.
- FULL:
  - in & out -> main <= in, stays FULL.
  - in only -> skid <= in, SKID.
  - out only -> EMPTY.
  - neither -> hold.
- SKID: out_ready -> main <= skid, FULL. Otherwise hold.
- Ordering is strictly FIFO; no entry is ever dropped or duplicated except by clear.
- clear has priority over every other event:
  - state -> EMPTY; main and skid ctrl/data <= 0.
  - An input offered in the same cycle is discarded even if in_ready=1.
  - An output handshake in the same cycle still counts as consumed downstream.
- An invalid main entry always holds ctrl=0 and data=0, so downstream sees zero-valued bubbles.

## Timing
- Reset (async, immediate): state EMPTY, all entries 0.
  - Outputs: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1, stall_cnt=0, flush_cnt=0.
- rst asserted mid-operation discards all held entries at once. The first accept after deassertion is at the first rising edge with rst low.
- Latency: in -> out is 1 cycle when EMPTY or when FULL with out_ready=1.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- in_ready falls on the edge entering SKID and rises on the edge leaving it. There is no combinational path out_ready -> in_ready.
- clear takes effect at the edge where it is sampled high. out_valid=0 and in_ready=1 in the following cycle.
- occupancy is registered and changes on the same edge as state.

## Configuration
- PIPE_SKID_PERF_EN defined:
  - stall_cnt increments on every cycle with out_valid=1 and out_ready=0.
  - flush_cnt increments on every cycle with clear=1.
  - Both counters saturate at 16'hFFFF and are cleared only by rst.
- Undefined: counter logic is not built; stall_cnt and flush_cnt are tied to 16'h0000.

## Test plan
- Reset release, then in_valid=1 with ctrl=8'h05, data=64'h1234 and out_ready=1 -> next cycle out_valid=1, out_ctrl=8'h05, out_data=64'h1234, occupancy=1.
- Stream A, B, C on consecutive cycles with out_ready=0 from the cycle B arrives:
  - After B: occupancy=2, in_ready=0, C is held upstream.
  - Raise out_ready: A, B, C emerge in order with no loss.
- SKID state plus clear=1 and in_valid=1 with D in the same cycle -> next cycle out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1; D never appears.
- Assert rst asynchronously between edges while FULL -> outputs go to their reset values immediately, without waiting for clk.
- PIPE_SKID_PERF_EN defined:
  - 3 stall cycles then 2 clear pulses -> stall_cnt=3, flush_cnt=2.
  - Preload stall_cnt to 16'hFFFF via 65535 stalls; one more stall -> stays 16'hFFFF.
- Macro undefined, same stimulus -> both counters read 0.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready pipeline stage with a skid entry and synchronous flush to bubbles.
// Optional perf counters are built when PIPE_SKID_PERF_EN is defined.
module pipe_skid_stage #(
    parameter int CW = 8,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_ctrl,
    input  logic [DW-1:0] in_data,
    input  logic          clear,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_ctrl,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occupancy,
    output logic [15:0]   stall_cnt,
    output logic [15:0]   flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] main_ctrl_q, main_ctrl_d;
    logic [DW-1:0] main_data_q, main_data_d;
    logic [CW-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DW-1:0] skid_data_q, skid_data_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [1:0]    occupancy_q, occupancy_d;
    logic          xfer_in, xfer_out;

    assign xfer_in  = in_valid & in_ready_q;
    assign xfer_out = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (clear) begin
            // Flush wins: any offered input is dropped, held entries become bubbles.
            state_d     = EMPTY;
            main_ctrl_d = '0;
            main_data_d = '0;
            skid_ctrl_d = '0;
            skid_data_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (xfer_in) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                        state_d     = FULL;
                    end
                end
                FULL: begin
                    if (xfer_in && xfer_out) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (xfer_in) begin
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                        state_d     = SKID;
                    end else if (xfer_out) begin
                        main_ctrl_d = '0;
                        main_data_d = '0;
                        state_d     = EMPTY;
                    end
                end
                SKID: begin
                    if (out_ready) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                        skid_data_d = '0;
                        state_d     = FULL;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                    main_data_d = '0;
                    skid_ctrl_d = '0;
                    skid_data_d = '0;
                end
            endcase
        end

        // Handshake outputs are registered from the next state, so out_ready never reaches in_ready.
        in_ready_d  = (state_d != SKID);
        out_valid_d = (state_d != EMPTY);
        case (state_d)
            FULL:    occupancy_d = 2'd1;
            SKID:    occupancy_d = 2'd2;
            default: occupancy_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occupancy = occupancy_q;

`ifdef PIPE_SKID_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid_q && !out_ready && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (clear && flush_cnt_q != 16'hFFFF)
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 16'h0000;
    assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: a negedge monitor tracks held entries in a queue,
// scenario tasks add directed checks for reset, backpressure, flush and counters.
module tb_pipe_skid_stage;
    localparam int CW = 8;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;
    logic [15:0]   flush_cnt;

    int errors = 0;
    int checks = 0;

    logic [CW-1:0] sb_ctrl[$];
    logic [DW-1:0] sb_data[$];

`ifdef PIPE_SKID_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    pipe_skid_stage #(.CW(CW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: queue holds exactly the entries the stage should hold after the last edge.
    always @(negedge clk) begin
        if (rst) begin
            sb_ctrl.delete();
            sb_data.delete();
        end else begin
            checks++;
            if (occupancy !== 2'(sb_ctrl.size())) begin
                errors++;
                $display("FAIL occupancy: got %0d expected %0d", occupancy, sb_ctrl.size());
            end
            checks++;
            if (in_ready !== (sb_ctrl.size() < 2)) begin
                errors++;
                $display("FAIL in_ready: got %b expected %b", in_ready, sb_ctrl.size() < 2);
            end
            checks++;
            if (out_valid !== (sb_ctrl.size() != 0)) begin
                errors++;
                $display("FAIL out_valid: got %b expected %b", out_valid, sb_ctrl.size() != 0);
            end
            if (!out_valid) begin
                checks++;
                if (out_ctrl !== '0 || out_data !== '0) begin
                    errors++;
                    $display("FAIL bubble: got ctrl=%h data=%h expected 0", out_ctrl, out_data);
                end
            end
            if (out_valid && out_ready && sb_ctrl.size() != 0) begin
                logic [CW-1:0] ec;
                logic [DW-1:0] ed;
                ec = sb_ctrl.pop_front();
                ed = sb_data.pop_front();
                checks++;
                if (out_ctrl !== ec || out_data !== ed) begin
                    errors++;
                    $display("FAIL out_entry: got ctrl=%h data=%h expected ctrl=%h data=%h",
                             out_ctrl, out_data, ec, ed);
                end
            end
            if (clear) begin
                sb_ctrl.delete();
                sb_data.delete();
            end else if (in_valid && in_ready) begin
                sb_ctrl.push_back(in_ctrl);
                sb_data.push_back(in_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Offer one entry until accepted, bounded.
    task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        n = 0;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected accept", n);
        end
    endtask

    task automatic drain(input string name);
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((sb_ctrl.size() != 0 || out_valid) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (sb_ctrl.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending out_valid=%b expected 0", name, sb_ctrl.size(), out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || occupancy !== 2'd0 ||
            in_ready !== 1'b1 || stall_cnt !== 16'h0 || flush_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_values: got v=%b c=%h d=%h occ=%0d rdy=%b sc=%h fc=%h expected v=0 c=0 d=0 occ=0 rdy=1 sc=0 fc=0",
                     out_valid, out_ctrl, out_data, occupancy, in_ready, stall_cnt, flush_cnt);
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        in_valid  = 1'b1;
        in_ctrl   = 8'h05;
        in_data   = 64'h1234;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_ctrl !== 8'h05 || out_data !== 64'h1234 || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL single_latency: got v=%b c=%h d=%h occ=%0d expected v=1 c=05 d=1234 occ=1",
                     out_valid, out_ctrl, out_data, occupancy);
        end
        drain("single");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        send(8'hA1, 64'hAAAA_0001);
        out_ready = 1'b0;
        send(8'hB2, 64'hBBBB_0002);
        in_valid = 1'b1;
        in_ctrl  = 8'hC3;
        in_data  = 64'hCCCC_0003;
        tick();
        tick();
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_ctrl !== 8'hA1) begin
            errors++;
            $display("FAIL skid_full: got occ=%0d rdy=%b c=%h expected occ=2 rdy=0 c=a1",
                     occupancy, in_ready, out_ctrl);
        end
        out_ready = 1'b1;
        send(8'hC3, 64'hCCCC_0003);
        drain("abc");
    endtask

    task automatic test_clear_skid();
        out_ready = 1'b0;
        send(8'h11, 64'h1111);
        send(8'h22, 64'h2222);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 8'hDD;
        in_data  = 64'hDDDD;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_skid: got v=%b c=%h d=%h occ=%0d rdy=%b expected v=0 c=0 d=0 occ=0 rdy=1",
                     out_valid, out_ctrl, out_data, occupancy, in_ready);
        end
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send(8'h77, 64'h7777);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got v=%b c=%h d=%h occ=%0d rdy=%b expected v=0 c=0 d=0 occ=0 rdy=1",
                     out_valid, out_ctrl, out_data, occupancy, in_ready);
        end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        send(8'h78, 64'h7878);
        drain("post_reset");
    endtask

    task automatic test_random_stream();
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_ctrl   = 8'($urandom);
            in_data   = {$urandom, $urandom};
            out_ready = 1'($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 24) == 0);
            tick();
        end
        clear = 1'b0;
        drain("random");
    endtask

    task automatic test_counters();
        do_reset();
        send(8'h01, 64'h1);
        repeat (3) tick();
        clear     = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        clear = 1'b0;
        checks++;
        if (stall_cnt !== (PERF ? 16'd3 : 16'd0) || flush_cnt !== (PERF ? 16'd2 : 16'd0)) begin
            errors++;
            $display("FAIL counters: got sc=%0d fc=%0d expected sc=%0d fc=%0d",
                     stall_cnt, flush_cnt, PERF ? 3 : 0, PERF ? 2 : 0);
        end
    endtask

    task automatic test_stall_saturation();
        do_reset();
        send(8'h02, 64'h2);
        repeat (65535) tick();
        checks++;
        if (stall_cnt !== (PERF ? 16'hFFFF : 16'h0)) begin
            errors++;
            $display("FAIL stall_preload: got %h expected %h", stall_cnt, PERF ? 16'hFFFF : 16'h0);
        end
        tick();
        checks++;
        if (stall_cnt !== (PERF ? 16'hFFFF : 16'h0)) begin
            errors++;
            $display("FAIL stall_saturate: got %h expected %h", stall_cnt, PERF ? 16'hFFFF : 16'h0);
        end
        drain("saturation");
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_clear_skid();
        test_async_reset();
        test_random_stream();
        test_counters();
        test_stall_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
